// File: rtl/delay_pkg.sv
// Shared definitions for the programmable delay line: FSM states, output
// source selection and a constant-evaluable clog2.
package delay_pkg;

    typedef enum logic {
        ST_FILL = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    // Source of the registered output word.
    typedef enum logic [1:0] {
        SEL_ZERO = 2'd0,
        SEL_RAM  = 2'd1,
        SEL_BYP  = 2'd2
    } out_sel_t;

    // Bits needed to index 'value' distinct items (ceil(log2(value))).
    function automatic int clog2(input int value);
        int result;
        result = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) result = i + 1;
        end
        return result;
    endfunction

endpackage

// File: rtl/delay_ram.sv
// Simple dual-port RAM, synchronous read, read-first on same-address
// collision. Contents are never reset.
module delay_ram #(
    parameter int WIDTH = 32,
    parameter int AW    = 7
) (
    input  logic             clk,
    input  logic             wr_en,
    input  logic [AW-1:0]    wr_addr,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_en,
    input  logic [AW-1:0]    rd_addr,
    output logic [WIDTH-1:0] rd_data
);

    logic [WIDTH-1:0] mem [0:(1 << AW)-1];

    // NOTE: no reset on the array so it maps onto block RAM; readers must
    // never consume a word before it has been written.
    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_addr] <= wr_data;
        // NOTE: non-blocking read and write of the same word give read-first
        // behaviour: the read sees the value from before this edge.
        if (rd_en) rd_data <= mem[rd_addr];
    end

endmodule

// File: rtl/prog_delay_line.sv
// Multi-channel delay line with a runtime-loadable depth of 0..MAX_DELAY
// valid samples, built on a circular RAM buffer.
module prog_delay_line
    import delay_pkg::*;
#(
    parameter int DATA_WIDTH    = 8,
    parameter int NUM_CH        = 4,
    parameter int MAX_DELAY     = 64,
    parameter int DEFAULT_DELAY = 4,
    localparam int AW           = clog2(MAX_DELAY + 1),
    localparam int W            = NUM_CH * DATA_WIDTH
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [W-1:0]  din,
    input  logic          din_valid,
    input  logic [AW:0]   delay_in,
    input  logic          delay_ld,
    output logic [W-1:0]  dout,
    output logic          dout_valid,
    output logic          data_valid,
    output logic          cfg_err
);

    localparam logic [AW:0] MAX_W = (AW + 1)'(MAX_DELAY);

    state_t        state_q, state_eff, state_d;
    out_sel_t      sel_q;
    logic [AW-1:0] delay_q, fill_cnt, wr_ptr;
    logic [AW-1:0] delay_new, delay_eff, fill_eff, fill_d, rd_addr;
    logic [W-1:0]  byp_q, ram_rd_data;
    logic          clamp, sample_ok;

    assign clamp     = delay_in > MAX_W;
    assign delay_new = clamp ? AW'(MAX_DELAY) : delay_in[AW-1:0];

    // A load takes effect for the sample presented in the same cycle.
    assign delay_eff = delay_ld ? delay_new : delay_q;
    assign fill_eff  = delay_ld ? '0 : fill_cnt;
    assign rd_addr   = wr_ptr - delay_eff;
    assign sample_ok = (state_eff == ST_RUN) || (fill_eff == delay_eff);

    // NOTE: every output of this block is assigned a default first, so no
    // path leaves a value unassigned and no latch is inferred.
    always_comb begin
        state_eff = state_q;
        fill_d    = fill_eff;
        if (delay_ld) state_eff = (delay_new == '0) ? ST_RUN : ST_FILL;
        state_d = state_eff;
        if (din_valid && state_eff == ST_FILL) begin
            if (fill_eff == delay_eff) state_d = ST_RUN;
            else                       fill_d  = fill_eff + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= ST_FILL;
            delay_q    <= AW'(DEFAULT_DELAY);
            fill_cnt   <= '0;
            wr_ptr     <= '0;
            sel_q      <= SEL_ZERO;
            byp_q      <= '0;
            dout_valid <= 1'b0;
            data_valid <= 1'b0;
            cfg_err    <= 1'b0;
        end else begin
            state_q    <= state_d;
            fill_cnt   <= fill_d;
            dout_valid <= din_valid;
            data_valid <= din_valid && sample_ok;
            cfg_err    <= delay_ld && clamp;
            if (delay_ld) delay_q <= delay_new;
            if (din_valid) begin
                wr_ptr <= wr_ptr + 1'b1;
                byp_q  <= din;
                if (!sample_ok)            sel_q <= SEL_ZERO;
                else if (delay_eff == '0)  sel_q <= SEL_BYP;
                else                       sel_q <= SEL_RAM;
            end
        end
    end

    // Read port only advances on accepted samples so dout holds in gaps.
    delay_ram #(
        .WIDTH (W),
        .AW    (AW)
    ) u_ram (
        .clk     (clk),
        .wr_en   (din_valid && rst_n),
        .wr_addr (wr_ptr),
        .wr_data (din),
        .rd_en   (din_valid && rst_n),
        .rd_addr (rd_addr),
        .rd_data (ram_rd_data)
    );

    always_comb begin
        dout = '0;
        case (sel_q)
            SEL_RAM: dout = ram_rd_data;
            SEL_BYP: dout = byp_q;
            default: dout = '0;
        endcase
    end

endmodule

// File: tb/tb_prog_delay_line.sv
// Randomised bench for prog_delay_line checked against a queue-based model
// of "output sample k-d once k >= d samples have arrived since the last load".
module tb_prog_delay_line;
    import delay_pkg::*;

    localparam int DW   = 8;
    localparam int NCH  = 4;
    localparam int MAXD = 64;
    localparam int DEFD = 4;
    localparam int AW   = clog2(MAXD + 1);
    localparam int W    = NCH * DW;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [W-1:0]  din;
    logic          din_valid;
    logic [AW:0]   delay_in;
    logic          delay_ld;
    logic [W-1:0]  dout;
    logic          dout_valid;
    logic          data_valid;
    logic          cfg_err;

    always #5 clk = ~clk;

    prog_delay_line #(
        .DATA_WIDTH    (DW),
        .NUM_CH        (NCH),
        .MAX_DELAY     (MAXD),
        .DEFAULT_DELAY (DEFD)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .din        (din),
        .din_valid  (din_valid),
        .delay_in   (delay_in),
        .delay_ld   (delay_ld),
        .dout       (dout),
        .dout_valid (dout_valid),
        .data_valid (data_valid),
        .cfg_err    (cfg_err)
    );

    // Reference model state.
    logic [W-1:0] hist[$];
    int           m_delay;
    logic [W-1:0] e_dout;
    logic         e_dv, e_dav, e_err;

    int n_cmp = 0;
    int n_mis = 0;

    task automatic model(input logic r, input logic l, input logic [AW:0] dl,
                         input logic v, input logic [W-1:0] d);
        int k;
        if (!r) begin
            m_delay = DEFD;
            hist.delete();
            e_dout = '0; e_dv = 1'b0; e_dav = 1'b0; e_err = 1'b0;
            return;
        end
        e_err = l && (int'(dl) > MAXD);
        if (l) begin
            m_delay = (int'(dl) > MAXD) ? MAXD : int'(dl);
            hist.delete();
        end
        e_dv = v;
        e_dav = 1'b0;
        if (v) begin
            hist.push_back(d);
            k = hist.size() - 1;
            if (k >= m_delay) begin
                e_dout = hist[k - m_delay];
                e_dav  = 1'b1;
            end else begin
                e_dout = '0;
            end
        end
    endtask

    task automatic compare(input string tag);
        n_cmp += 4;
        assert (dout === e_dout) else begin
            n_mis++; $error("FAIL %s dout observed=%h expected=%h", tag, dout, e_dout);
        end
        assert (dout_valid === e_dv) else begin
            n_mis++; $error("FAIL %s dout_valid observed=%b expected=%b", tag, dout_valid, e_dv);
        end
        assert (data_valid === e_dav) else begin
            n_mis++; $error("FAIL %s data_valid observed=%b expected=%b", tag, data_valid, e_dav);
        end
        assert (cfg_err === e_err) else begin
            n_mis++; $error("FAIL %s cfg_err observed=%b expected=%b", tag, cfg_err, e_err);
        end
    endtask

    // Drive one cycle at the falling edge, then check 1 ns after the rising edge.
    task automatic step(input string tag, input logic r, input logic l,
                        input logic [AW:0] dl, input logic v, input logic [W-1:0] d);
        @(negedge clk);
        rst_n = r; delay_ld = l; delay_in = dl; din_valid = v; din = d;
        model(r, l, dl, v, d);
        @(posedge clk);
        #1;
        compare(tag);
    endtask

    initial begin
        logic [W-1:0] w;
        rst_n = 1'b0; din = '0; din_valid = 1'b0; delay_in = '0; delay_ld = 1'b0;

        // Reset with junk on the inputs.
        step("reset0", 1'b0, 1'b1, 8'd9, 1'b1, 32'hdead_beef);
        step("reset1", 1'b0, 1'b0, 8'd0, 1'b1, 32'h1234_5678);

        // Default delay, channel 0 counts 1,2,3..., other channels random.
        for (int i = 0; i < 20; i++) begin
            w = $urandom();
            w[7:0] = 8'(i + 1);
            step("default", 1'b1, 1'b0, 8'd0, 1'b1, w);
            if (i == 4) begin
                n_cmp++;
                assert (dout[7:0] === 8'd1 && data_valid === 1'b1) else begin
                    n_mis++; $error("FAIL fifth_out observed=%h/%b expected=01/1", dout[7:0], data_valid);
                end
            end
        end

        // Delay 3 with din_valid every other cycle.
        step("ld3", 1'b1, 1'b1, 8'd3, 1'b0, '0);
        for (int i = 0; i < 30; i++) step("alt3", 1'b1, 1'b0, 8'd0, i[0], $urandom());

        // Mid-stream load of 7 together with a sample.
        for (int i = 0; i < 5; i++) step("pre7", 1'b1, 1'b0, 8'd0, 1'b1, $urandom());
        step("ld7", 1'b1, 1'b1, 8'd7, 1'b1, $urandom());
        for (int i = 0; i < 15; i++) step("run7", 1'b1, 1'b0, 8'd0, 1'b1, $urandom());

        // Zero delay: bypass.
        step("ld0", 1'b1, 1'b1, 8'd0, 1'b1, $urandom());
        for (int i = 0; i < 12; i++) step("byp", 1'b1, 1'b0, 8'd0, 1'($urandom_range(1)), $urandom());

        // Clamped load, then a gappy stream at MAX_DELAY.
        step("ld100", 1'b1, 1'b1, 8'd100, 1'b0, '0);
        for (int i = 0; i < 90; i++) step("clamp", 1'b1, 1'b0, 8'd0, ($urandom_range(9) < 7), $urandom());

        // Exact MAX_DELAY, long stream across several pointer wraps.
        step("ld64", 1'b1, 1'b1, 8'(MAXD), 1'b1, $urandom());
        for (int i = 0; i < 3 * (1 << AW) + 40; i++) begin
            w = {8'($urandom()), 8'(i * 3), 8'(i >> 1), 8'(i)};
            step("wrap", 1'b1, 1'b0, 8'd0, 1'b1, w);
        end

        // One-cycle reset mid-stream, overriding a load and a sample.
        step("midrst", 1'b0, 1'b1, 8'd2, 1'b1, $urandom());
        for (int i = 0; i < 12; i++) step("postrst", 1'b1, 1'b0, 8'd0, 1'b1, $urandom());

        // Reload of the same delay restarts the fill.
        step("reld4", 1'b1, 1'b1, 8'd4, 1'b1, $urandom());
        for (int i = 0; i < 8; i++) step("refill", 1'b1, 1'b0, 8'd0, 1'b1, $urandom());

        // Random mix of loads (including out-of-range) and gaps.
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(39) == 0)
                step("rnd_ld", 1'b1, 1'b1, 8'($urandom_range(20) == 0 ? $urandom_range(255) : $urandom_range(12)),
                     1'($urandom_range(1)), $urandom());
            else
                step("rnd", 1'b1, 1'b0, 8'd0, ($urandom_range(3) != 0), $urandom());
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule

// File: doc/prog_delay_line.md
# prog_delay_line

Runtime-programmable, multi-channel sample delay line built on a circular RAM buffer. `prog_delay_line` delays `NUM_CH` parallel channels by a common, loadable number of valid samples, from 0 to `MAX_DELAY`. A validity flag marks outputs that carry real history rather than pre-fill contents. It sits in streaming datapaths to align channels and compensate pipeline skew, and replaces fixed-depth delays where the depth must change without resynthesis.

## Interface
- `DATA_WIDTH`, 8: bits per channel.
- `NUM_CH`, 4: channel count; all channels share one delay.
- `MAX_DELAY`, 64: largest legal delay in samples, ≥1.
- `DEFAULT_DELAY`, 4: delay after reset, ≤ `MAX_DELAY`.
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: synchronous, active-low reset.
- `din` in `NUM_CH*DATA_WIDTH`: channel c occupies bits `[c*DATA_WIDTH +: DATA_WIDTH]`.
- `din_valid` in 1: qualifies `din`; one sample accepted per high cycle.
- `delay_in` in `AW+1`: new delay value. `AW = clog2(MAX_DELAY+1)`.
- `delay_ld` in 1: one-cycle load strobe for `delay_in`.
- `dout` out `NUM_CH*DATA_WIDTH`: delayed samples, registered.
- `dout_valid` out 1: one pulse per accepted input sample.
- `data_valid` out 1: qualifies `dout`; high only when `dout` holds genuine delayed data.
- `cfg_err` out 1: one-cycle pulse when a load was clamped.

## Operation
- States: `FILL`, `RUN`. `fill_cnt` counts samples accepted since the last load or reset, saturating at `delay_q`.
- Buffer: depth `2^AW` words of `NUM_CH*DATA_WIDTH` bits. `wr_ptr` is AW bits and increments mod `2^AW` on each accepted sample. Read address is `(wr_ptr − delay_q) mod 2^AW`. The RAM is read-first: on a same-address collision the read returns old data.
- Accepted sample index k: `dout = din[k − delay_q]`.
- For `delay_q = 0`: bypass the RAM and output `dout = din` registered.
- `data_valid` is asserted with a sample's `dout_valid` iff `k ≥ delay_q`. Otherwise `data_valid` is 0 and `dout` is forced to 0.
- `FILL` → `RUN` on the accepted sample with `fill_cnt == delay_q`. A load with `delay_in = 0` enters `RUN` directly.
- `delay_ld`:
  - `delay_q ← min(delay_in, MAX_DELAY)`.
  - Clears `fill_cnt` and enters `FILL`.
  - `wr_ptr` and RAM contents are untouched; old contents are treated as invalid.
  - `cfg_err` pulses on the next cycle if `delay_in > MAX_DELAY`.
- `delay_ld` together with `din_valid` in the same cycle: the load applies first, and that sample becomes index 0 under the new delay.
- Loading the current delay value still restarts the fill.
- `din_valid` low: no pointer, counter, or output update, except that `dout_valid` and `data_valid` drop to 0. `dout` holds its value.

## Timing
- Latency: `din_valid` at edge t → `dout`, `dout_valid`, `data_valid` at edge t+1.
- Back-to-back `din_valid` is supported at full rate, one sample per cycle, with no stalls.
- The new delay applies to samples in the same cycle as `delay_ld`.
- Reset (`rst_n` low at an edge) gives:
  - `dout = 0`, `dout_valid = 0`, `data_valid = 0`, `cfg_err = 0`.
  - `wr_ptr = 0`, `fill_cnt = 0`, `delay_q = DEFAULT_DELAY`, state `FILL`.
- RAM contents are not reset.
- Reset mid-stream overrides `delay_ld` and `din_valid` in that cycle; the first sample after reset is index 0.

## Structure
- Shared package `delay_pkg`:
  - `clog2` function.
  - State encoding constants `ST_FILL` and `ST_RUN`.
- Sub-module `delay_ram`: simple dual-port, read-first, synchronous-read RAM with parameters `WIDTH` and `AW`, no reset.
- `prog_delay_line` holds pointers, the FSM, clamp logic, bypass mux, and output registers.

## Test plan
- Reset, then `DEFAULT_DELAY=4`, `din_valid` every cycle with channel 0 = 1, 2, 3, … → first 4 outputs have `data_valid = 0` and `dout = 0`. The 5th output is `dout[7:0] = 1` with `data_valid = 1`, followed by 2, 3, … back-to-back.
- `din_valid` asserted every other cycle, delay 3 → `dout_valid` mirrors the input gaps one cycle later. Delay is counted in samples, not cycles.
- Mid-stream `delay_ld` with `delay_in = 7` in the same cycle as `din_valid` → `data_valid` drops for exactly 7 samples, then `dout` equals the sample accepted at the load cycle.
- `delay_in = 0` → `dout` equals `din` one cycle later with `data_valid = 1` immediately. `delay_in = 100` with `MAX_DELAY = 64` → `cfg_err` pulses once and the delay becomes 64.
- Delay = `MAX_DELAY`, stream of at least 3×`2^AW` samples with distinct per-channel values → no corruption across pointer wrap, and channels stay independent.
- Assert `rst_n` low for one cycle mid-stream → all outputs are 0 on the next cycle, the delay reverts to `DEFAULT_DELAY`, and the fill restarts.
